// File: rtl/key_repeat_filter.sv
// Turns a held keycode into frame-aligned press/auto-repeat events, with frame_clk synchronised into the Clk domain.
// Latency: key_out/key_tick update on the 3rd Clk edge after frame_clk rises (+/-1 cycle of sampling uncertainty).
// Backpressure: none; key_out holds for a full frame. Build option KEYFILT_WASD_ONLY_EN passes only the W/A/S/D codes.
module key_repeat_filter #(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode_in,
  output logic [7:0] key_out,
  output logic       key_tick,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Counter reload values; the counter reaches zero on the tick that should emit.
  localparam logic [7:0] DELAY_LOAD = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RATE_LOAD  = 8'(REPEAT_RATE - 1);

  logic       fsync1, fsync2, fprev;
  logic       tick;
  logic [7:0] k_q, k_f;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] key_out_d;

  // Synchronise frame_clk and keep its previous value for rising-edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync1 <= 1'b0;
      fsync2 <= 1'b0;
      fprev  <= 1'b0;
    end else begin
      fsync1 <= frame_clk;
      fsync2 <= fsync1;
      fprev  <= fsync2;
    end
  end

  assign tick = fsync2 & ~fprev;

  // Register the raw keycode every cycle; the FSM consumes it only on ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) k_q <= 8'h00;
    else          k_q <= keycode_in;
  end

  // Optional key filter: anything outside W/A/S/D is treated as no key.
  always_comb begin
`ifdef KEYFILT_WASD_ONLY_EN
    k_f = (k_q == 8'h04 || k_q == 8'h07 || k_q == 8'h16 || k_q == 8'h1A) ? k_q : 8'h00;
`else
    k_f = k_q;
`endif
  end

  // State register: FSM state, counter, held code and event outputs advance only on ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'h00;
      cur_q    <= 8'h00;
      key_out  <= 8'h00;
      key_tick <= 1'b0;
    end else begin
      key_tick <= tick;
      if (tick) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cur_q   <= cur_d;
        key_out <= key_out_d;
      end
    end
  end

  // Next-state logic: a new or changed code restarts the delay, a zero counter emits the held code.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    key_out_d = 8'h00;
    case (state_q)
      IDLE: begin
        if (k_f != 8'h00) begin
          key_out_d = k_f;
          cur_d     = k_f;
          cnt_d     = DELAY_LOAD;
          state_d   = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (k_f == 8'h00) begin
          state_d = IDLE;
        end else if (k_f != cur_q) begin
          key_out_d = k_f;
          cur_d     = k_f;
          cnt_d     = DELAY_LOAD;
          state_d   = DELAY;
        end else if (cnt_q == 8'h00) begin
          key_out_d = cur_q;
          cnt_d     = RATE_LOAD;
          state_d   = REPEAT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: a key counts as held in either counting state.
  always_comb begin
    key_held = (state_q != IDLE);
  end

endmodule

// File: tb/tb_key_repeat_filter.sv
// Self-checking bench for key_repeat_filter: directed scenarios plus random key holds against an event-schedule model.
// Each frame raises frame_clk, checks the event on the 3rd Clk edge, then checks the pulse has ended.
// Keycode changes are made in the low phase of frame_clk unless a step deliberately races the tick.
module tb_key_repeat_filter;

  localparam int D = 30;
  localparam int R = 6;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode_in;
  logic [7:0] key_out;
  logic       key_tick;
  logic       key_held;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: ticks elapsed since the current code was first seen.
  bit         m_active = 1'b0;
  logic [7:0] m_cur    = 8'h00;
  int         m_n      = 0;
  logic [7:0] m_exp    = 8'h00;

  logic [7:0] keys [6];

  key_repeat_filter #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .keycode_in (keycode_in),
    .key_out    (key_out),
    .key_tick   (key_tick),
    .key_held   (key_held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] filt(input logic [7:0] k);
`ifdef KEYFILT_WASD_ONLY_EN
    return (k == 8'h04 || k == 8'h07 || k == 8'h16 || k == 8'h1A) ? k : 8'h00;
`else
    return k;
`endif
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_cur    = 8'h00;
    m_n      = 0;
    m_exp    = 8'h00;
  endtask

  // Events at press tick, then at D ticks after, then every R ticks.
  task automatic model_tick(input logic [7:0] k);
    logic [7:0] kf;
    kf = filt(k);
    if (kf == 8'h00) begin
      m_exp    = 8'h00;
      m_active = 1'b0;
    end else if (!m_active || kf != m_cur) begin
      m_exp    = kf;
      m_cur    = kf;
      m_n      = 0;
      m_active = 1'b1;
    end else begin
      m_n++;
      m_exp = (m_n == D || (m_n > D && ((m_n - D) % R) == 0)) ? m_cur : 8'h00;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One frame; the tick sees 'seen' while keycode_in becomes 'after' during the tick cycle.
  task automatic frame2(input string tag, input logic [7:0] seen, input logic [7:0] after);
    keycode_in = seen;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 keycode_in = after;
    @(posedge Clk);
    #1;
    model_tick(seen);
    chk({tag, "_out"},  key_out,         m_exp);
    chk({tag, "_tick"}, {7'd0, key_tick}, 8'd1);
    chk({tag, "_held"}, {7'd0, key_held}, {7'd0, m_active});
    @(posedge Clk);
    #1;
    chk({tag, "_tick_end"}, {7'd0, key_tick}, 8'd0);
    chk({tag, "_hold"},     key_out,          m_exp);
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic frame(input string tag, input logic [7:0] k);
    frame2(tag, k, k);
  endtask

  initial begin
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07;
    keys[3] = 8'h16; keys[4] = 8'h1A; keys[5] = 8'h2C;
    Reset_n    = 1'b0;
    frame_clk  = 1'b0;
    keycode_in = 8'h00;
    model_reset();
    #1;
    chk("rst_out",  key_out,          8'h00);
    chk("rst_tick", {7'd0, key_tick}, 8'd0);
    chk("rst_held", {7'd0, key_held}, 8'd0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;

    // Idle frames.
    for (int i = 0; i < 5; i++) frame("idle", 8'h00);

    // Long hold: events at ticks 0, 30, 36, 42.
    for (int i = 0; i < 46; i++) frame("hold1a", 8'h1A);
    frame("rel", 8'h00);

    // Code change at tick 10 restarts the delay for the new code.
    for (int i = 0; i < 10; i++) frame("sw04", 8'h04);
    for (int i = 0; i < 35; i++) frame("sw07", 8'h07);
    frame("rel", 8'h00);

    // Hold into REPEAT, then reset mid-frame right after an event.
    for (int i = 0; i < 31; i++) frame("hold16", 8'h16);
    chk("pre_rst_out", key_out, 8'h16);
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("midrst_out",  key_out,          8'h00);
    chk("midrst_held", {7'd0, key_held}, 8'd0);
    model_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    chk("postrst_out",  key_out,          8'h00);
    chk("postrst_held", {7'd0, key_held}, 8'd0);
    frame("after_rst", 8'h16);
    frame("rel", 8'h00);

    // Short pulse between ticks is never seen.
    keycode_in = 8'h07;
    repeat (3) @(posedge Clk);
    #1 keycode_in = 8'h00;
    frame("pulse", 8'h00);

    // Keycode change coincident with the tick: the old registered code is used.
    frame2("race", 8'h00, 8'h04);
    frame("race_next", 8'h04);
    frame2("race_rel", 8'h04, 8'h00);
    frame("rel", 8'h00);

    // Non-WASD key.
    frame("k2c", 8'h2C);
`ifdef KEYFILT_WASD_ONLY_EN
    chk("k2c_direct", key_out, 8'h00);
`else
    chk("k2c_direct", key_out, 8'h2C);
`endif
    frame("rel", 8'h00);

    // Random hold runs.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] k;
      int         len;
      k   = keys[$urandom_range(0, 5)];
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 50)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) frame("rand", k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
